ahb_arbiter: RTL



---
 rtl/ahb_arbiter.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/ahb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_arbiter
//  Purpose  : Round-robin multi-master AHB arbiter. Produces a one-hot grant,
//             tracks locked sequences, the data-phase owner and masters parked
//             by SPLIT responses. Master 0 is the default master.
//  Ports    : i_hclk        bus clock
//             i_hreset      synchronous active-high reset
//             i_hbusreq     per-master bus request
//             i_hlock       per-master lock request
//             i_htrans      HTRANS of the muxed address phase
//             i_hready      HREADY from the slave mux
//             i_hresp       HRESP from the slave mux
//             i_hsplit      OR of all slaves' HSPLIT vectors
//             o_hgrant      one-hot grant
//             o_hmaster     address-phase owner index
//             o_hmaster_d   data-phase owner index
//             o_hmastlock   current address phase is locked
//             o_split_mask  masters currently parked by SPLIT
//  Config   : AHB_ARB_SPLIT_EN - when defined, SPLIT masking is active;
//             otherwise SPLIT behaves like RETRY and the mask is always 0.
//  Revision : 1.0 - initial release
// ============================================================================
module ahb_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int MAX_TENURE  = 16,
    parameter int MW          = $clog2(NUM_MASTERS)
) (
    input  logic                   i_hclk,
    input  logic                   i_hreset,
    input  logic [NUM_MASTERS-1:0] i_hbusreq,
    input  logic [NUM_MASTERS-1:0] i_hlock,
    input  logic [1:0]             i_htrans,
    input  logic                   i_hready,
    input  logic [1:0]             i_hresp,
    input  logic [NUM_MASTERS-1:0] i_hsplit,
    output logic [NUM_MASTERS-1:0] o_hgrant,
    output logic [MW-1:0]          o_hmaster,
    output logic [MW-1:0]          o_hmaster_d,
    output logic                   o_hmastlock,
    output logic [NUM_MASTERS-1:0] o_split_mask
);

    localparam int              c_tw         = $clog2(MAX_TENURE + 1);
    localparam logic [c_tw-1:0] c_max_tenure = c_tw'(MAX_TENURE);
    localparam logic [1:0]      c_resp_split = 2'b11;

    typedef enum logic [1:0] {
        ST_DEFAULT = 2'd0,
        ST_OWNED   = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_next_state;
    state_t                   w_pick_state;
    logic [MW-1:0]            r_owner;
    logic [MW-1:0]            w_next_owner;
    logic [MW-1:0]            w_pick_owner;
    logic [MW-1:0]            w_rr_idx;
    logic                     w_rr_found;
    logic [NUM_MASTERS-1:0]   r_grant;
    logic [NUM_MASTERS-1:0]   w_next_grant;
    logic [MW-1:0]            r_hmaster_d;
    logic                     r_hmastlock;
    logic [c_tw-1:0]          r_tenure;
    logic [NUM_MASTERS-1:0]   w_split_mask;
    logic [NUM_MASTERS-1:0]   w_elig;
    logic                     w_others_waiting;
    logic                     w_rearb;

    assign w_elig = i_hbusreq & ~w_split_mask;

    // Any eligible requester other than the current owner (r_grant is the
    // one-hot form of r_owner).
    assign w_others_waiting = |(w_elig & ~r_grant);

    // ------------------------------------------------------------------
    // Round-robin search: first eligible master starting at owner+1 and
    // wrapping; the owner itself is the last candidate considered.
    // ------------------------------------------------------------------
    always_comb begin
        logic [MW:0] sum;
        w_rr_found = 1'b0;
        w_rr_idx   = '0;
        sum        = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            sum = {1'b0, r_owner} + (MW+1)'(i + 1);
            if (sum >= (MW+1)'(NUM_MASTERS)) begin
                sum = sum - (MW+1)'(NUM_MASTERS);
            end
            if (!w_rr_found && w_elig[sum[MW-1:0]]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = sum[MW-1:0];
            end
        end
    end

    // Result of a fresh arbitration: empty eligible set falls back to the
    // default master.
    always_comb begin
        w_pick_owner = w_rr_found ? w_rr_idx : '0;
        if (!w_rr_found) begin
            w_pick_state = ST_DEFAULT;
        end else if (i_hlock[w_pick_owner]) begin
            w_pick_state = ST_LOCKED;
        end else begin
            w_pick_state = ST_OWNED;
        end
    end

    assign w_rearb = !i_hbusreq[r_owner] || w_split_mask[r_owner] ||
                     ((r_tenure == c_max_tenure) && w_others_waiting);

    // ------------------------------------------------------------------
    // Next-state / next-owner logic; nothing moves while HREADY is low.
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_next_owner = r_owner;
        if (i_hready) begin
            case (r_state)
                ST_DEFAULT: begin
                    w_next_state = w_pick_state;
                    w_next_owner = w_pick_owner;
                end
                ST_OWNED: begin
                    if (w_rearb) begin
                        w_next_state = w_pick_state;
                        w_next_owner = w_pick_owner;
                    end else if (i_hlock[r_owner]) begin
                        w_next_state = ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    // Lock release passes through OWNED for one cycle with
                    // the same owner before normal arbitration resumes.
                    if (!i_hlock[r_owner]) begin
                        w_next_state = ST_OWNED;
                    end
                end
                default: begin
                    w_next_state = ST_DEFAULT;
                    w_next_owner = '0;
                end
            endcase
        end
    end

    always_comb begin
        w_next_grant               = '0;
        w_next_grant[w_next_owner] = 1'b1;
    end

    always_ff @(posedge i_hclk) begin
        if (i_hreset) begin
            r_state <= ST_DEFAULT;
            r_owner <= '0;
            r_grant <= NUM_MASTERS'(1);
        end else begin
            r_state <= w_next_state;
            r_owner <= w_next_owner;
            r_grant <= w_next_grant;
        end
    end

    // ------------------------------------------------------------------
    // Pipeline registers and tenure counter.
    // ------------------------------------------------------------------
    always_ff @(posedge i_hclk) begin
        if (i_hreset) begin
            r_hmaster_d <= '0;
            r_hmastlock <= 1'b0;
            r_tenure    <= '0;
        end else if (i_hready) begin
            r_hmaster_d <= r_owner;
            r_hmastlock <= i_hlock[w_next_owner];
            if (w_next_owner != r_owner) begin
                r_tenure <= '0;
            end else if (i_htrans[1] && (r_tenure != c_max_tenure)) begin
                // NONSEQ and SEQ both have htrans[1] set.
                r_tenure <= r_tenure + c_tw'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // SPLIT mask.
    // ------------------------------------------------------------------
`ifdef AHB_ARB_SPLIT_EN
    logic [NUM_MASTERS-1:0] r_split_mask;
    logic [NUM_MASTERS-1:0] w_split_set;
    logic [NUM_MASTERS-1:0] w_split_next;

    always_comb begin
        w_split_set = '0;
        // First SPLIT cycle (HREADY low) parks the data-phase master;
        // master 0 is the default master and is never parked.
        if ((i_hresp == c_resp_split) && !i_hready && (r_hmaster_d != '0)) begin
            w_split_set[r_hmaster_d] = 1'b1;
        end
        // Clear has priority over set for the same bit.
        w_split_next    = (r_split_mask | w_split_set) & ~i_hsplit;
        w_split_next[0] = 1'b0;
    end

    always_ff @(posedge i_hclk) begin
        if (i_hreset) begin
            r_split_mask <= '0;
        end else begin
            r_split_mask <= w_split_next;
        end
    end

    assign w_split_mask = r_split_mask;

    logic w_unused_ok;
    assign w_unused_ok = i_htrans[0];
`else
    assign w_split_mask = '0;

    // SPLIT behaves like RETRY here: response and HSPLIT are don't-cares.
    logic w_unused_ok;
    assign w_unused_ok = ^{i_hresp, i_hsplit, i_htrans[0]};
`endif

    assign o_hgrant     = r_grant;
    assign o_hmaster    = r_owner;
    assign o_hmaster_d  = r_hmaster_d;
    assign o_hmastlock  = r_hmastlock;
    assign o_split_mask = w_split_mask;

endmodule
`default_nettype wire
